pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB); sits beside the Decoder and drives every pipeline-register enable and flush.
// - Resolves load-use hazards, EX-resolved branch/jump redirects, multi-cycle data-memory handshakes and debug halt/single-step.
// - Holds the only control FSM in the core; all datapath registers obey its stall_*/flush_* outputs.
// PARAMETERS
// - MEM_TIMEOUT   255  max cycles in MEM_WAIT before dmem_err is raised (1..65535, 16-bit counter)
// - CNT_W         32   width of performance counters
// PORTS
// - clk             in   1      core clock
// - rst             in   1      synchronous, active-high reset
// - id_rf_ra0/1     in   5 ea   ID-stage source registers (Decoder rf_ra0/rf_ra1)
// - id_re0/1        in   1 ea   ID-stage source actually read (0 for lui/jal, etc.)
// - ex_rf_wa        in   5      EX-stage destination register
// - ex_is_load      in   1      EX instruction is a load (rf_wd_sel == load)
// - ex_br_taken     in   1      EX-stage branch taken or jal/jalr (redirect PC)
// - mem_dmem_req    in   1      MEM-stage instruction accesses dmem (dmem_access != 0)
// - dmem_ready      in   1      dmem completes the access this cycle
// - dbg_halt/dbg_step/dbg_resume  in  1 ea  single-cycle debug command pulses
// - stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out 1 ea  hold register
// - flush_if_id, flush_id_ex, flush_ex_mem  out  1 ea  load bubble (NOP) into register
// - halted          out  1      core frozen in HALT
// - dmem_err        out  1      sticky; set on MEM_WAIT timeout, cleared by rst only
// - perf_cycles, perf_stalls, perf_flushes  out  CNT_W  performance counters
// BEHAVIOUR
// - Clock and reset fixed: one clock clk; rst synchronous, active-high.
// - FSM registered: RUN, MEM_WAIT, HALT, STEP. stall/flush outputs combinational from state + inputs (0-cycle latency).
// - While rst=1: state<=RUN, halted=0, dmem_err<=0, counters<=0, halt_pend<=0, wait_cnt<=0; outputs: all stall_*=0, all flush_*=1.
// - load_use = ex_is_load & ex_rf_wa!=0 & ((id_re0 & ra0==ex_rf_wa) | (id_re1 & ra1==ex_rf_wa)).
// - RUN, priority high->low:
//   1. mem_dmem_req & !dmem_ready: stall all five stall_*; flush none; ->MEM_WAIT, wait_cnt<=1.
//   2. ex_br_taken: flush_if_id=flush_id_ex=1, no stall (branch wins over load_use; ID is wrong-path).
//   3. load_use: stall_pc=stall_if_id=1, flush_id_ex=1 (one bubble; exactly 1 cycle).
//   4. else all 0.
//   - dbg_halt in RUN: this cycle's actions apply, then ->HALT (or MEM_WAIT with halt_pend<=1 if case 1).
// - MEM_WAIT: all stall_*=1; wait_cnt++ each cycle. dmem_ready=1: stall_*=0 this cycle, branch/load-use rules evaluated as RUN, ->halt_pend?HALT:RUN, halt_pend<=0.
//   wait_cnt==MEM_TIMEOUT & !dmem_ready: dmem_err<=1, ->HALT, access abandoned (flush_ex_mem=1 on exit).
//   - dbg_halt in MEM_WAIT sets halt_pend; no mid-access abort.
// - HALT: all stall_*=1, flush_*=0, halted=1. dbg_resume->RUN; dbg_step->STEP; both same cycle: resume wins.
// - STEP: one advance cycle evaluated exactly as RUN, halted=0; then ->HALT (or MEM_WAIT with halt_pend<=1 if case 1).
// - Commands outside their state ignored; dbg_halt in HALT/STEP is a no-op.
// - A held ex_br_taken during MEM_WAIT is not acted on until the release cycle (flush deferred, never lost).
// - x0 never creates a hazard; ra==wa with id_re=0 never stalls.
// CONFIGURATION
// - Macro PIPE_HAZARD_CTRL_PERF_EN defined: perf_cycles++ every non-reset cycle; perf_stalls++ on any cycle stall_pc=1;
//   perf_flushes++ on any cycle flush_if_id|flush_id_ex|flush_ex_mem=1 outside reset; counters wrap at 2^CNT_W.
// - Not defined: counter logic omitted, perf_* tied to 0; all other behaviour identical.
// TESTING
// - Reset: rst=1 two cycles -> flush_*=1, stall_*=0, halted=0, dmem_err=0, perf_*=0 after release.
// - Load-use: ex_is_load=1, ex_rf_wa=10, id_re0=1, ra0=10 -> 1 cycle stall_pc=stall_if_id=flush_id_ex=1; ra0=0/wa=0 -> no stall.
// - Branch vs load-use same cycle: ex_br_taken=1 + load_use -> flush_if_id=flush_id_ex=1, stall_pc=0.
// - DMEM wait: mem_dmem_req=1, dmem_ready low 3 cycles -> 3 cycles all stall_*=1, release on 4th, state RUN.
// - Timeout: MEM_TIMEOUT=4, dmem_ready never -> dmem_err=1 at cycle 4, halted=1 next cycle, stays until rst.
// - Debug: dbg_halt -> halted=1; dbg_step -> one cycle all stall_*=0, then halted=1; dbg_resume -> RUN; with PERF_EN perf_stalls counts HALT cycles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard sequencer and the pipeline it controls.
// master = pipeline side (drives hazard sources), slave = sequencer side.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rf_ra0;
  logic [4:0]       id_rf_ra1;
  logic             id_re0;
  logic             id_re1;
  logic [4:0]       ex_rf_wa;
  logic             ex_is_load;
  logic             ex_br_taken;
  logic             mem_dmem_req;
  logic             dmem_ready;
  logic             dbg_halt;
  logic             dbg_step;
  logic             dbg_resume;
  logic             stall_pc;
  logic             stall_if_id;
  logic             stall_id_ex;
  logic             stall_ex_mem;
  logic             stall_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             halted;
  logic             dmem_err;
  logic [CNT_W-1:0] perf_cycles;
  logic [CNT_W-1:0] perf_stalls;
  logic [CNT_W-1:0] perf_flushes;

  modport master (
    output id_rf_ra0, id_rf_ra1, id_re0, id_re1, ex_rf_wa, ex_is_load, ex_br_taken,
           mem_dmem_req, dmem_ready, dbg_halt, dbg_step, dbg_resume,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, halted, dmem_err,
           perf_cycles, perf_stalls, perf_flushes
  );

  modport slave (
    input  id_rf_ra0, id_rf_ra1, id_re0, id_re1, ex_rf_wa, ex_is_load, ex_br_taken,
           mem_dmem_req, dmem_ready, dbg_halt, dbg_step, dbg_resume,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, halted, dmem_err,
           perf_cycles, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirects, dmem waits, debug halt.
// Performance counters are built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt, StStep} state_e;

  localparam logic [15:0] Timeout = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        dmem_err_q, err_set;

  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, halted;
  logic load_use, mem_block;

  assign load_use = bus.ex_is_load && (bus.ex_rf_wa != 5'd0) &&
                    ((bus.id_re0 && (bus.id_rf_ra0 == bus.ex_rf_wa)) ||
                     (bus.id_re1 && (bus.id_rf_ra1 == bus.ex_rf_wa)));
  assign mem_block = bus.mem_dmem_req && !bus.dmem_ready;

  always_comb begin
    state_d      = state_q;
    halt_pend_d  = halt_pend_q;
    wait_cnt_d   = wait_cnt_q;
    err_set      = 1'b0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      StRun, StStep: begin
        if (mem_block) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
          state_d     = StMemWait;
          wait_cnt_d  = 16'd1;
          // A step that stalls on dmem must still land in HALT once the access completes.
          halt_pend_d = (state_q == StStep) || bus.dbg_halt;
        end else begin
          if (bus.ex_br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
          state_d = ((state_q == StStep) || bus.dbg_halt) ? StHalt : StRun;
        end
      end
      StMemWait: begin
        if (bus.dmem_ready) begin
          if (bus.ex_br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
          state_d     = (halt_pend_q || bus.dbg_halt) ? StHalt : StRun;
          halt_pend_d = 1'b0;
        end else if (wait_cnt_q == Timeout) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
          flush_ex_mem = 1'b1;
          err_set      = 1'b1;
          state_d      = StHalt;
          halt_pend_d  = 1'b0;
        end else begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
          wait_cnt_d  = wait_cnt_q + 16'd1;
          halt_pend_d = halt_pend_q || bus.dbg_halt;
        end
      end
      StHalt: begin
        {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
        halted = 1'b1;
        if (bus.dbg_resume) begin
          state_d = StRun;
        end else if (bus.dbg_step) begin
          state_d = StStep;
        end
      end
      default: state_d = StRun;
    endcase

    // Reset forces bubbles everywhere so the pipeline drains to NOPs.
    if (rst) begin
      {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b00000;
      {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
      halted = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      halt_pend_q <= 1'b0;
      wait_cnt_q  <= 16'd0;
      dmem_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      wait_cnt_q  <= wait_cnt_d;
      if (err_set) dmem_err_q <= 1'b1;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_cycles_q, perf_stalls_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q  <= '0;
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_q + 1'b1;
      if (stall_pc) perf_stalls_q <= perf_stalls_q + 1'b1;
      if (flush_if_id || flush_id_ex || flush_ex_mem) perf_flushes_q <= perf_flushes_q + 1'b1;
    end
  end

  assign bus.perf_cycles  = perf_cycles_q;
  assign bus.perf_stalls  = perf_stalls_q;
  assign bus.perf_flushes = perf_flushes_q;
`else
  assign bus.perf_cycles  = '0;
  assign bus.perf_stalls  = '0;
  assign bus.perf_flushes = '0;
`endif

  assign bus.stall_pc     = stall_pc;
  assign bus.stall_if_id  = stall_if_id;
  assign bus.stall_id_ex  = stall_id_ex;
  assign bus.stall_ex_mem = stall_ex_mem;
  assign bus.stall_mem_wb = stall_mem_wb;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.flush_ex_mem = flush_ex_mem;
  assign bus.halted       = halted;
  assign bus.dmem_err     = dmem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned CNT_W = 32;

  // Output vector order: stall pc,if_id,id_ex,ex_mem,mem_wb | flush if_id,id_ex,ex_mem | halted | err
  localparam logic [9:0] NONE  = 10'b00000_000_0_0;
  localparam logic [9:0] LU    = 10'b11000_010_0_0;
  localparam logic [9:0] BR    = 10'b00000_110_0_0;
  localparam logic [9:0] ALLST = 10'b11111_000_0_0;
  localparam logic [9:0] RSTO  = 10'b00000_111_0_0;
  localparam logic [9:0] HLT   = 10'b11111_000_1_0;
  localparam logic [9:0] TMO   = 10'b11111_001_0_0;
  localparam logic [9:0] HERR  = 10'b11111_000_1_1;
  localparam logic [9:0] ERR   = 10'b00000_000_0_1;

  typedef struct packed {
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic       re0;
    logic       re1;
    logic [4:0] wa;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
    logic       dbg_h;
    logic       dbg_s;
    logic       dbg_r;
  } in_t;

  typedef struct {
    in_t        in;
    logic [9:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [9:0] exp;
    string      name;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  exp_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic in_t mkr(input logic [4:0] ra0, input logic [4:0] ra1, input logic re0,
                              input logic re1, input logic [4:0] wa, input logic ld,
                              input logic br, input logic req, input logic rdy);
    in_t v;
    v     = '0;
    v.ra0 = ra0; v.ra1 = ra1; v.re0 = re0; v.re1 = re1; v.wa = wa;
    v.ld  = ld;  v.br  = br;  v.req = req; v.rdy = rdy;
    return v;
  endfunction

  // Sequence helper; lu sets up a load-use on x10 through port 0.
  function automatic in_t mki(input logic req, input logic rdy, input logic br, input logic lu,
                              input logic h, input logic s, input logic r);
    in_t v;
    v = '0;
    v.req = req; v.rdy = rdy; v.br = br;
    v.dbg_h = h; v.dbg_s = s; v.dbg_r = r;
    if (lu) begin
      v.ld = 1'b1; v.wa = 5'd10; v.ra0 = 5'd10; v.re0 = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem, bus.stall_mem_wb,
            bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.halted, bus.dmem_err};
  endfunction

  task automatic apply(input in_t v);
    bus.id_rf_ra0    = v.ra0;
    bus.id_rf_ra1    = v.ra1;
    bus.id_re0       = v.re0;
    bus.id_re1       = v.re1;
    bus.ex_rf_wa     = v.wa;
    bus.ex_is_load   = v.ld;
    bus.ex_br_taken  = v.br;
    bus.mem_dmem_req = v.req;
    bus.dmem_ready   = v.rdy;
    bus.dbg_halt     = v.dbg_h;
    bus.dbg_step     = v.dbg_s;
    bus.dbg_resume   = v.dbg_r;
  endtask

  task automatic check_out();
    sb_t        e;
    logic [9:0] got;
    e   = exp_q.pop_front();
    got = outs();
    n_cmp++;
    if (got !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", e.name, got, e.exp);
    end
  endtask

  task automatic check_val(input string name, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // One cycle: drive after the edge, predict, sample at the falling edge.
  task automatic cyc(input in_t v, input logic [9:0] exp, input string name);
    sb_t e;
    @(posedge clk);
    #1;
    apply(v);
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply('0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs[11];
  logic [CNT_W-1:0] p0;

  initial begin
    sb_t e;
    apply('0);
    p0 = '0;

    vecs[0]  = '{mkr(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0), NONE, "idle"};
    vecs[1]  = '{mkr(5'd10, 5'd0,  1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0), LU,   "lu_ra0"};
    vecs[2]  = '{mkr(5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0), NONE, "lu_x0"};
    vecs[3]  = '{mkr(5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0), LU,   "lu_ra1"};
    vecs[4]  = '{mkr(5'd10, 5'd10, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0), NONE, "lu_no_re"};
    vecs[5]  = '{mkr(5'd10, 5'd0,  1'b1, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0), NONE, "not_load"};
    vecs[6]  = '{mkr(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0), BR,   "branch"};
    vecs[7]  = '{mkr(5'd10, 5'd0,  1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0), BR,   "br_vs_lu"};
    vecs[8]  = '{mkr(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1), NONE, "mem_ready"};
    vecs[9]  = '{mkr(5'd5,  5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1), LU,   "mem_rdy_lu"};
    vecs[10] = '{mkr(5'd11, 5'd12, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0), NONE, "lu_mismatch"};

    // Reset: two cycles high, outputs checked while held and after release.
    @(negedge clk);
    e.exp = RSTO; e.name = "reset_out"; exp_q.push_back(e);
    check_out();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    e.exp = NONE; e.name = "post_reset"; exp_q.push_back(e);
    check_out();
    check_val("perf_cycles_rst", bus.perf_cycles, '0);
    check_val("perf_stalls_rst", bus.perf_stalls, '0);
    check_val("perf_flushes_rst", bus.perf_flushes, '0);

    foreach (vecs[i]) cyc(vecs[i].in, vecs[i].exp, vecs[i].name);

    // dmem wait: three low-ready cycles stalled, release on the fourth.
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "wait_c0");
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "wait_c1");
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "wait_c2");
    cyc(mki(1, 1, 0, 0, 0, 0, 0), NONE,  "wait_release");
    cyc(mki(0, 0, 0, 1, 0, 0, 0), LU,    "wait_back_run");

    // Branch held across a wait is deferred to the release cycle.
    cyc(mki(1, 0, 1, 0, 0, 0, 0), ALLST, "brwait_c0");
    cyc(mki(1, 0, 1, 0, 0, 0, 0), ALLST, "brwait_c1");
    cyc(mki(1, 1, 1, 0, 0, 0, 0), BR,    "brwait_release");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), NONE,  "brwait_after");

    // Halt requested while entering a wait lands in HALT after release.
    cyc(mki(1, 0, 0, 0, 1, 0, 0), ALLST, "hpend_c0");
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "hpend_c1");
    cyc(mki(1, 1, 0, 0, 0, 0, 0), NONE,  "hpend_release");
    cyc(mki(0, 0, 0, 0, 0, 0, 1), HLT,   "hpend_halted");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), NONE,  "hpend_resumed");

    // Debug halt, step, resume.
    cyc(mki(0, 0, 0, 0, 1, 0, 0), NONE,  "dbg_halt_cmd");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), HLT,   "dbg_halted");
    p0 = bus.perf_stalls;
    cyc(mki(0, 0, 0, 0, 1, 0, 0), HLT,   "dbg_halt_noop");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), HLT,   "dbg_halted2");
    cyc(mki(0, 0, 0, 0, 0, 1, 0), HLT,   "dbg_step_cmd");
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    check_val("perf_stalls_halt", bus.perf_stalls, p0 + 3);
`endif
    cyc(mki(0, 0, 0, 1, 0, 0, 0), LU,    "dbg_step_cycle");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), HLT,   "dbg_after_step");
    cyc(mki(0, 0, 0, 0, 0, 1, 1), HLT,   "dbg_resume_step");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), NONE,  "dbg_resumed");
    cyc(mki(0, 0, 0, 1, 0, 0, 0), LU,    "dbg_run_lu");

    // Timeout with MEM_TIMEOUT=4 and ready never asserted.
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "tmo_c0");
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "tmo_c1");
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "tmo_c2");
    cyc(mki(1, 0, 0, 0, 0, 0, 0), ALLST, "tmo_c3");
    cyc(mki(1, 0, 0, 0, 0, 0, 0), TMO,   "tmo_c4");
    cyc(mki(1, 0, 0, 0, 0, 0, 1), HERR,  "tmo_halted");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), ERR,   "tmo_err_sticky");
    cyc(mki(0, 0, 0, 0, 0, 0, 0), ERR,   "tmo_err_sticky2");
    do_reset();
    cyc(mki(0, 0, 0, 0, 0, 0, 0), NONE,  "tmo_err_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
